dmem_access: RTL and testbench

- Load/store unit on the data-memory side of the RV32 pipeline.
- Takes load/store requests from execute and drives a req/gnt/rvalid data-memory bus.
- Aligns and sign- or zero-extends read data, and returns it as the memory operand consumed by write-back.
- Asserts busy to stall the pipeline and reports faults (misaligned, illegal size, bus error, timeout).

---
 rtl/dmem_access_if.sv | 23 ++
 rtl/dmem_access.sv | 229 ++++++++++++++++++++++
 tb/tb_dmem_access.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_if.sv
// dmem_access_if: req/gnt/rvalid data-memory bus between the load/store unit
// (master) and the data memory (slave).
interface dmem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
    );
endinterface

// File: rtl/dmem_access.sv
// dmem_access: RV32 load/store unit on the data-memory side of the pipeline.
// Decodes size/sign, checks legality and alignment, runs one req/gnt/rvalid
// bus transaction and returns the aligned, extended load word.
// Optional feature: define DMEM_TIMEOUT_EN to add a REQ+WAIT cycle budget of
// TIMEOUT_CYCLES that ends a stuck transaction with a timeout fault.
module dmem_access #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          is_store,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   store_data,
    output logic          busy,
    output logic          done,
    output logic [31:0]   load_data,
    output logic          fault,
    output logic [1:0]    fault_cause,
    dmem_access_if.master dmem
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10, FIN = 2'b11} state_t;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS      = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    state_t      state_r, next_s;
    logic        busy_r, done_r, fault_r, req_r, we_r, pend_r;
    logic [1:0]  cause_r, pend_cause_r, lane_r;
    logic [2:0]  funct3_r;
    logic [3:0]  be_r, be_s;
    logic [31:0] load_data_r, addr_r, wdata_r, wdata_s, shifted_s, extended_s;
    logic        illegal_s, misaligned_s, timeout_s;
    logic        done_next_s, fault_next_s, load_capture_s;
    logic [1:0]  cause_next_s;

    // Decode the incoming request: legality, alignment, byte enables, lane replication.
    always_comb begin
        illegal_s    = (funct3[1:0] == 2'b11) || (is_store ? funct3[2] : (funct3 == 3'b110));
        misaligned_s = 1'b0;
        be_s         = 4'b0000;
        wdata_s      = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << addr[1:0];
                wdata_s = {4{store_data[7:0]}};
            end
            2'b01: begin
                misaligned_s = addr[0];
                be_s         = 4'b0011 << addr[1:0];
                wdata_s      = {2{store_data[15:0]}};
            end
            2'b10: begin
                misaligned_s = (addr[1:0] != 2'b00);
                be_s         = 4'b1111;
                wdata_s      = store_data;
            end
            default: begin
                misaligned_s = 1'b0;
                be_s         = 4'b0000;
                wdata_s      = 32'h0000_0000;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero-extend it.
    always_comb begin
        shifted_s  = dmem.dmem_rdata >> {lane_r, 3'b000};
        extended_s = shifted_s;
        case (funct3_r)
            3'b000:  extended_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  extended_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b100:  extended_s = {24'h00_0000, shifted_s[7:0]};
            3'b101:  extended_s = {16'h0000, shifted_s[15:0]};
            default: extended_s = shifted_s;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_r;

    // Count cycles spent in REQ/WAIT; restart on every entry to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != REQ && next_s == REQ) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == REQ || state_r == WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign timeout_s = (state_r == REQ || state_r == WAIT) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next state plus the values the registered outputs take on the next edge.
    // A decode fault lingers one extra FIN cycle (pend_r) so done lands at T+2.
    always_comb begin
        next_s         = state_r;
        done_next_s    = 1'b0;
        fault_next_s   = 1'b0;
        cause_next_s   = 2'b00;
        load_capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (illegal_s || misaligned_s) begin
                        next_s = FIN;
                    end else begin
                        next_s = REQ;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            REQ: begin
                if (timeout_s) begin
                    next_s       = FIN;
                    done_next_s  = 1'b1;
                    fault_next_s = 1'b1;
                    cause_next_s = CAUSE_TIMEOUT;
                end else if (dmem.dmem_gnt) begin
                    next_s = WAIT;
                end else begin
                    next_s = REQ;
                end
            end
            WAIT: begin
                if (dmem.dmem_rvalid) begin
                    next_s      = FIN;
                    done_next_s = 1'b1;
                    if (dmem.dmem_err) begin
                        fault_next_s = 1'b1;
                        cause_next_s = CAUSE_BUS;
                    end else begin
                        load_capture_s = !we_r;
                    end
                end else if (timeout_s) begin
                    next_s       = FIN;
                    done_next_s  = 1'b1;
                    fault_next_s = 1'b1;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    next_s = WAIT;
                end
            end
            FIN: begin
                if (pend_r) begin
                    next_s       = FIN;
                    done_next_s  = 1'b1;
                    fault_next_s = 1'b1;
                    cause_next_s = pend_cause_r;
                end else begin
                    next_s = IDLE;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // State register and the registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
            cause_r <= 2'b00;
            req_r   <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != IDLE);
            done_r  <= done_next_s;
            fault_r <= fault_next_s;
            cause_r <= cause_next_s;
            req_r   <= (next_s == REQ);
            pend_r  <= (state_r == IDLE) && (next_s == FIN);
        end
    end

    // Latch bus fields and response-shaping info when a request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r         <= 1'b0;
            be_r         <= 4'b0000;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            funct3_r     <= 3'b000;
            lane_r       <= 2'b00;
            pend_cause_r <= 2'b00;
        end else if (state_r == IDLE && next_s == REQ) begin
            we_r     <= is_store;
            be_r     <= be_s;
            addr_r   <= {addr[31:2], 2'b00};
            wdata_r  <= wdata_s;
            funct3_r <= funct3;
            lane_r   <= addr[1:0];
        end else if (state_r == IDLE && next_s == FIN) begin
            pend_cause_r <= illegal_s ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
        end
    end

    // Load result register; untouched by stores and faults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data_r <= 32'h0000_0000;
        end else if (load_capture_s) begin
            load_data_r <= extended_s;
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign fault           = fault_r;
    assign fault_cause     = cause_r;
    assign load_data       = load_data_r;
    assign dmem.dmem_req   = req_r;
    assign dmem.dmem_we    = we_r;
    assign dmem.dmem_be    = be_r;
    assign dmem.dmem_addr  = addr_r;
    assign dmem.dmem_wdata = wdata_r;
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: randomized self-checking bench for dmem_access. A byte-level
// reference model predicts faults, byte enables, store lanes and load results.
module tb_dmem_access;
    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int          checks;
    int          errors;
    logic [31:0] exp_ld;

    dmem_access_if bus ();

    dmem_access #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .fault       (fault),
        .fault_cause (fault_cause),
        .dmem        (bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: works per byte with plain arithmetic.
    task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd,
                         input bit [31:0] rd, input bit er,
                         output bit m_dec, output bit m_fault, output bit [1:0] m_cause,
                         output bit [3:0] m_be, output bit [31:0] m_wd, output bit [31:0] m_ld);
        int nbytes;
        int off;
        bit legal;
        bit [31:0] mask;
        bit [31:0] val;
        off = int'(a % 32'd4);
        case (f3[1:0])
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 0;
        endcase
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        m_dec = 1'b0; m_fault = 1'b0; m_cause = 2'd0; m_be = 4'd0; m_wd = 32'd0; m_ld = 32'd0;
        if (!legal) begin
            m_dec = 1'b1; m_fault = 1'b1; m_cause = 2'd0;
        end else if ((off % nbytes) != 0) begin
            m_dec = 1'b1; m_fault = 1'b1; m_cause = 2'd1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + nbytes) m_be[i] = 1'b1;
                m_wd[8*i +: 8] = sd[8*(i % nbytes) +: 8];
            end
            if (er) begin
                m_fault = 1'b1; m_cause = 2'd2;
            end else if (!st) begin
                mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
                val  = (rd >> (8 * off)) & mask;
                if (!f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
                m_ld = val;
            end
        end
    endtask

    // One operation with a responding memory: gnt after gdly cycles of req,
    // rvalid rdly cycles after gnt; noise on start/fields and stray rvalids elsewhere.
    task automatic run_op(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd,
                          input bit [31:0] rd, input bit er, input int gdly, input int rdly);
        bit m_dec, m_fault;
        bit [1:0] m_cause;
        bit [3:0] m_be;
        bit [31:0] m_wd, m_ld;
        int n, waitc, exp_lat;
        bit granted, responded, seen_done, saw_req, bad_bus, bad_flags, bad_busy;
        model(st, f3, a, sd, rd, er, m_dec, m_fault, m_cause, m_be, m_wd, m_ld);
        if (!st && !m_fault) exp_ld = m_ld;
        exp_lat = m_dec ? 2 : 3 + gdly + rdly;
        n = 0; waitc = 0;
        granted = 1'b0; responded = 1'b0; seen_done = 1'b0; saw_req = 1'b0;
        bad_bus = 1'b0; bad_flags = 1'b0; bad_busy = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        while (!seen_done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                check_value("latency", 32'(n), 32'(exp_lat));
                check_value("fault", {31'd0, fault}, {31'd0, m_fault});
                check_value("cause", {30'd0, fault_cause}, {30'd0, m_cause});
                check_value("load_data", load_data, exp_ld);
            end else if (fault !== 1'b0 || fault_cause !== 2'b00) begin
                bad_flags = 1'b1;
            end
            if (bus.dmem_req === 1'b1) begin
                saw_req = 1'b1;
                if (bus.dmem_addr !== {a[31:2], 2'b00} || bus.dmem_be !== m_be || bus.dmem_we !== st ||
                    (st && bus.dmem_wdata !== m_wd)) bad_bus = 1'b1;
            end
            start      = seen_done ? 1'b0 : 1'($urandom_range(0, 1));
            is_store   = 1'($urandom);
            funct3     = 3'($urandom);
            addr       = $urandom;
            store_data = $urandom;
            bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_err = 1'b0; bus.dmem_rdata = $urandom;
            if (!granted) begin
                if (bus.dmem_req === 1'b1) begin
                    if (waitc == gdly) begin
                        bus.dmem_gnt = 1'b1; granted = 1'b1; waitc = 0;
                    end else begin
                        waitc++;
                    end
                end
                bus.dmem_rvalid = 1'($urandom); bus.dmem_err = 1'($urandom);
            end else if (!responded) begin
                bus.dmem_gnt = 1'($urandom);
                if (waitc == rdly) begin
                    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd; bus.dmem_err = er; responded = 1'b1;
                end else begin
                    waitc++;
                end
            end else begin
                bus.dmem_rvalid = 1'($urandom); bus.dmem_err = 1'($urandom);
            end
        end
        check_value("done_seen", {31'd0, seen_done}, 32'd1);
        check_value("req_seen", {31'd0, saw_req}, {31'd0, !m_dec});
        check_value("bus_fields", {31'd0, bad_bus}, 32'd0);
        check_value("flags_outside_done", {31'd0, bad_flags}, 32'd0);
        check_value("busy_during_op", {31'd0, bad_busy}, 32'd0);
        @(negedge clk);
        check_value("done_pulse", {31'd0, done}, 32'd0);
        check_value("busy_after", {31'd0, busy}, 32'd0);
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_err = 1'b0;
        start = 1'b0;
    endtask

    // Asynchronous reset in REQ and in WAIT; a late rvalid must not complete anything.
    task automatic reset_mid_op();
        bit got_done;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000;
        @(negedge clk);
        start = 1'b0;
        check_value("rq_req_before", {31'd0, bus.dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_value("rq_req_rst", {31'd0, bus.dmem_req}, 32'd0);
        check_value("rq_busy_rst", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ld = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.dmem_gnt = 1'b1;
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        check_value("rw_busy_before", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_value("rw_busy_rst", {31'd0, busy}, 32'd0);
        check_value("rw_req_rst", {31'd0, bus.dmem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678; bus.dmem_err = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.dmem_rvalid = 1'b0;
            if (done !== 1'b0) got_done = 1'b1;
        end
        check_value("rw_no_done", {31'd0, got_done}, 32'd0);
        check_value("rw_load_data", load_data, exp_ld);
    endtask

`ifdef DMEM_TIMEOUT_EN
    // gnt never arrives: expect fault cause 3 exactly 8 cycles after REQ entry (T+1).
    task automatic timeout_test();
        int n;
        bit seen;
        bit req_high;
        n = 0; seen = 1'b0; req_high = 1'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
        while (!seen && n < 50) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done === 1'b1) seen = 1'b1;
            else if (bus.dmem_req === 1'b1) req_high = 1'b1;
        end
        check_value("to_done_seen", {31'd0, seen}, 32'd1);
        check_value("to_req_was_high", {31'd0, req_high}, 32'd1);
        check_value("to_latency", 32'(n), 32'd9);
        check_value("to_fault", {31'd0, fault}, 32'd1);
        check_value("to_cause", {30'd0, fault_cause}, 32'd3);
        check_value("to_req_dropped", {31'd0, bus.dmem_req}, 32'd0);
        @(negedge clk);
    endtask
`endif

    initial begin
        bit st;
        bit [2:0] f3;
        bit [2:0] legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        checks = 0; errors = 0; exp_ld = 32'd0;
        clk = 1'b0; rst = 1'b0;
        start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0; bus.dmem_err = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_done", {31'd0, done}, 32'd0);
        check_value("rst_fault", {31'd0, fault}, 32'd0);
        check_value("rst_cause", {30'd0, fault_cause}, 32'd0);
        check_value("rst_load_data", load_data, 32'd0);
        check_value("rst_req", {31'd0, bus.dmem_req}, 32'd0);
        check_value("rst_we", {31'd0, bus.dmem_we}, 32'd0);
        check_value("rst_be", {28'd0, bus.dmem_be}, 32'd0);
        check_value("rst_addr", bus.dmem_addr, 32'd0);
        check_value("rst_wdata", bus.dmem_wdata, 32'd0);
        rst = 1'b0;

        run_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1'b0, 0, 0);
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 1'b0, 0, 0);
        run_op(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 1'b0, 0, 0);
        run_op(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0000_0000, 1'b0, 3, 1);
        run_op(1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'h1111_2222, 1'b0, 0, 0);
        run_op(1'b0, 3'b011, 32'h0000_4000, 32'd0, 32'h1111_2222, 1'b0, 0, 0);
        run_op(1'b1, 3'b011, 32'h0000_4000, 32'h1234_5678, 32'd0, 1'b0, 0, 0);
        run_op(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'hDEAD_BEEF, 1'b1, 0, 0);
        run_op(1'b0, 3'b010, 32'h0000_5004, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 3);
        reset_mid_op();
`ifdef DMEM_TIMEOUT_EN
        timeout_test();
`endif
        for (int k = 0; k < 60; k++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
            else f3 = 3'($urandom);
            run_op(st, f3, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
